// File: rtl/conv_row_engine.sv
// conv_row_engine: row-streaming multi-filter 2-D convolution with an F-row line buffer
module conv_row_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC = 8,
  parameter int D = 1,
  parameter int H = 64,
  parameter int W = 64,
  parameter int F = 3,
  parameter int K = 2,
  parameter int PAD = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [K*D*F*F*DATA_WIDTH-1:0] filters,
  input  logic [D*W*DATA_WIDTH-1:0]     in_row,
  input  logic                          in_valid,
  input  logic                          in_first,
  output logic                          in_ready,
  output logic [K*W*DATA_WIDTH-1:0]     out_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          busy
);
  localparam int P = F / 2;
  localparam int M = PAD != 0 ? P : 0;
  localparam int AW = 2 * DATA_WIDTH + $clog2(D * F * F);
  localparam int CW = $clog2(H + F + 1);
  localparam int XW = W > 1 ? $clog2(W) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] NEED = CW'(PAD != 0 ? P + 1 : F);
  localparam logic [CW-1:0] ROWS = CW'(H);
  localparam logic [CW-1:0] TOTAL = CW'(PAD != 0 ? H : H - F + 1);
  localparam logic [XW-1:0] LAST_COL = XW'(W - 1);
  typedef enum logic [2:0] {IDLE, FILL, COMPUTE, HOLD, FLUSH} state_t;
  state_t state, state_nx;
  logic live, take, restart, load, flush, done_row, last_row;
  logic [CW-1:0] in_cnt, sh_cnt, out_cnt, in_nx, sh_nx, out_base;
  logic [XW-1:0] col;
  logic signed [DATA_WIDTH-1:0] lb [F][D][W];
  logic signed [DATA_WIDTH-1:0] cf [K][D][F][F];
  logic signed [DATA_WIDTH-1:0] ob [K][W];
  logic signed [DATA_WIDTH-1:0] res [K];
  logic signed [DATA_WIDTH-1:0] px;
  logic signed [AW-1:0] acc;
  int cc;
  assign in_ready = live && (state == IDLE || state == FILL);
  assign busy = state != IDLE;
  assign out_valid = state == HOLD;
  assign last_row = out_cnt + ONE == TOTAL;
  assign out_last = out_valid && last_row;
  assign take = in_valid && in_ready;
  assign restart = take && in_first;
  assign load = take && (state == FILL || in_first);
  assign flush = state == FLUSH;
  assign done_row = out_valid && out_ready;
  for (genvar k = 0; k < K; k++) begin : g_k
    for (genvar c = 0; c < W; c++) begin : g_c
      assign out_row[(k*W+c)*DATA_WIDTH +: DATA_WIDTH] = ob[k][c];
    end
  end
  // state register; live gates in_ready until the first edge after reset release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      live <= 1'b0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
    end
  // next state: compute once the newest buffered row is the window's bottom row
  always_comb begin
    in_nx = restart ? ONE : in_cnt + ONE;
    sh_nx = restart ? ONE : sh_cnt + ONE;
    out_base = restart ? '0 : out_cnt;
    state_nx = state;
    if (load) state_nx = sh_nx >= out_base + NEED ? COMPUTE : (PAD != 0 && in_nx == ROWS) ? FLUSH : FILL;
    else if (flush) state_nx = sh_nx >= out_cnt + NEED ? COMPUTE : FLUSH;
    else if (state == COMPUTE && col == LAST_COL) state_nx = HOLD;
    else if (done_row) state_nx = last_row ? IDLE : (PAD != 0 && in_cnt == ROWS) ? FLUSH : FILL;
  end
  // row counters, column sweep, output row register and end-of-frame pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_cnt <= '0;
      sh_cnt <= '0;
      out_cnt <= '0;
      col <= '0;
      frame_done <= 1'b0;
      for (int k = 0; k < K; k++)
        for (int c = 0; c < W; c++) ob[k][c] <= '0;
    end else begin
      if (load) begin
        in_cnt <= in_nx;
        sh_cnt <= sh_nx;
        out_cnt <= out_base;
      end else if (flush) sh_cnt <= sh_nx;
      if (done_row) out_cnt <= out_cnt + ONE;
      col <= state == COMPUTE ? (col == LAST_COL ? '0 : col + XW'(1)) : '0;
      frame_done <= done_row && last_row;
      if (state == COMPUTE)
        for (int k = 0; k < K; k++) ob[k][col] <= res[k];
    end
  // line buffer shifts oldest-first; a frame start zeroes the rows above row 0
  always_ff @(posedge clk) begin
    if (restart)
      for (int k = 0; k < K; k++)
        for (int d = 0; d < D; d++)
          for (int r = 0; r < F; r++)
            for (int j = 0; j < F; j++) cf[k][d][r][j] <= filters[(((k*D+d)*F+r)*F+j)*DATA_WIDTH +: DATA_WIDTH];
    if (load || flush) begin
      for (int r = 0; r < F - 1; r++)
        for (int d = 0; d < D; d++)
          for (int x = 0; x < W; x++) lb[r][d][x] <= restart ? '0 : lb[r+1][d][x];
      for (int d = 0; d < D; d++)
        for (int x = 0; x < W; x++) lb[F-1][d][x] <= flush ? '0 : in_row[(d*W+x)*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  // one output column for every filter: full-precision MAC, shift, saturate
  always_comb begin
    res = '{default: '0};
    acc = '0;
    px = '0;
    cc = 0;
    for (int k = 0; k < K; k++) begin
      acc = '0;
      for (int d = 0; d < D; d++)
        for (int r = 0; r < F; r++)
          for (int j = 0; j < F; j++) begin
            cc = int'(col) + j - M;
            px = (cc >= 0 && cc < W) ? lb[r][d][cc] : '0;
            acc = acc + AW'(px) * AW'(cf[k][d][r][j]);
          end
      acc = acc >>> FRAC;
      res[k] = (&acc[AW-1:DATA_WIDTH-1] || ~|acc[AW-1:DATA_WIDTH-1]) ? acc[DATA_WIDTH-1:0] :
               {acc[AW-1], {(DATA_WIDTH-1){~acc[AW-1]}}};
      if (PAD == 0 && int'(col) > W - F) res[k] = '0;
    end
  end
endmodule

// File: tb/tb_conv_row_engine.sv
// tb_conv_row_engine: randomized and directed frames against a coordinate-level convolution model
module tb_conv_row_engine;
  localparam int DW = 16, FR = 0, D = 1, H = 4, W = 4, F = 3, K = 2, P = F / 2;
  localparam int OW = K * W * DW;
  typedef struct { logic [OW-1:0] row; logic last; } exp_t;
  logic clk = 0, reset = 0, sel = 0;
  logic [K*D*F*F*DW-1:0] filters = '0;
  logic [D*W*DW-1:0] in_row = '0;
  logic in_valid = 0, in_first = 0, out_ready = 0;
  logic ir_p, ir_v, ov_p, ov_v, ol_p, ol_v, fd_p, fd_v, bz_p, bz_v;
  logic [OW-1:0] or_p, or_v;
  logic in_ready, out_valid, out_last, frame_done, busy;
  logic [OW-1:0] out_row, snap;
  int img [D][H][W];
  int flt [K][D][F][F];
  exp_t exp_q [$];
  exp_t e;
  logic [OW-1:0] got_q [$];
  int n_vec = 0, n_err = 0, fd_cnt = 0, frames_exp = 0, bp_left = 0;
  logic fd_pend = 0;
  always #5 clk = ~clk;
  assign in_ready = sel ? ir_v : ir_p;
  assign out_valid = sel ? ov_v : ov_p;
  assign out_last = sel ? ol_v : ol_p;
  assign frame_done = sel ? fd_v : fd_p;
  assign busy = sel ? bz_v : bz_p;
  assign out_row = sel ? or_v : or_p;
  conv_row_engine #(.DATA_WIDTH(DW), .FRAC(FR), .D(D), .H(H), .W(W), .F(F), .K(K), .PAD(1)) u_pad (
    .clk(clk), .reset(reset), .filters(filters), .in_row(in_row), .in_valid(in_valid && !sel),
    .in_first(in_first), .in_ready(ir_p), .out_row(or_p), .out_valid(ov_p), .out_ready(out_ready && !sel),
    .out_last(ol_p), .frame_done(fd_p), .busy(bz_p));
  conv_row_engine #(.DATA_WIDTH(DW), .FRAC(FR), .D(D), .H(H), .W(W), .F(F), .K(K), .PAD(0)) u_val (
    .clk(clk), .reset(reset), .filters(filters), .in_row(in_row), .in_valid(in_valid && sel),
    .in_first(in_first), .in_ready(ir_v), .out_row(or_v), .out_valid(ov_v), .out_ready(out_ready && sel),
    .out_last(ol_v), .frame_done(fd_v), .busy(bz_v));

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [OW-1:0] r, input int k, input int c);
    return r[(k*W+c)*DW +: DW];
  endfunction

  function automatic logic [OW-1:0] model_row(input int o, input bit pad);
    logic [OW-1:0] v = '0;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < W; c++) begin
        longint acc = 0;
        for (int d = 0; d < D; d++)
          for (int r = 0; r < F; r++)
            for (int j = 0; j < F; j++) begin
              int ir = pad ? o - P + r : o + r;
              int ic = pad ? c - P + j : c + j;
              if (ir >= 0 && ir < H && ic >= 0 && ic < W) acc += longint'(img[d][ir][ic]) * longint'(flt[k][d][r][j]);
            end
        acc = acc >>> FR;
        if (acc > (1 << (DW - 1)) - 1) acc = (1 << (DW - 1)) - 1;
        if (acc < -(1 << (DW - 1))) acc = -(1 << (DW - 1));
        if (!pad && c > W - F) acc = 0;
        v[(k*W+c)*DW +: DW] = acc[DW-1:0];
      end
    return v;
  endfunction

  task automatic expect_frame(input bit pad, input int n);
    int total = pad ? H : H - F + 1;
    for (int o = 0; o < total; o++) begin
      int trig = pad ? ((o + P < H - 1) ? o + P : H - 1) : o + F - 1;
      if (trig < n) exp_q.push_back('{row: model_row(o, pad), last: (o == total - 1)});
    end
    if (n == H) frames_exp++;
  endtask

  task automatic fill_img(input int v);
    for (int d = 0; d < D; d++) for (int h = 0; h < H; h++) for (int x = 0; x < W; x++) img[d][h][x] = v;
  endtask

  task automatic set_flt_default();
    for (int d = 0; d < D; d++) for (int r = 0; r < F; r++) for (int j = 0; j < F; j++) begin
      flt[0][d][r][j] = 1;
      flt[1][d][r][j] = (r == P && j == P) ? 1 : 0;
    end
  endtask

  task automatic randomize_data(input bit full);
    for (int d = 0; d < D; d++) for (int h = 0; h < H; h++) for (int x = 0; x < W; x++)
      img[d][h][x] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 600)) - 300;
    for (int k = 0; k < K; k++) for (int d = 0; d < D; d++) for (int r = 0; r < F; r++) for (int j = 0; j < F; j++)
      flt[k][d][r][j] = int'($urandom_range(0, 16)) - 8;
  endtask

  task automatic send_row(input int r, input bit first);
    @(negedge clk);
    for (int d = 0; d < D; d++) for (int x = 0; x < W; x++) in_row[(d*W+x)*DW +: DW] = DW'(img[d][r][x]);
    in_first = first;
    in_valid = 1;
    for (int t = 0; !in_ready; t++) begin
      if (t == 300) begin
        check("in_ready_timeout", in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 0;
    in_first = 0;
  endtask

  task automatic send_frame(input bit pad, input int n);
    sel = !pad;
    for (int k = 0; k < K; k++) for (int d = 0; d < D; d++) for (int r = 0; r < F; r++) for (int j = 0; j < F; j++)
      filters[(((k*D+d)*F+r)*F+j)*DW +: DW] = DW'(flt[k][d][r][j]);
    expect_frame(pad, n);
    for (int r = 0; r < n; r++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_row(r, r == 0);
      if (r == 0) for (int i = 0; i < K * D * F * F; i++) filters[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic drain();
    for (int t = 0; exp_q.size() > 0 || busy; t++) begin
      if (t == 3000) begin
        check("drain_rows_left", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  // output monitor: random/forced backpressure, row scoreboard, frame_done timing
  always @(negedge clk) begin
    if (!reset) begin
      fd_pend = 0;
      out_ready = 0;
    end else begin
      check("frame_done", frame_done, fd_pend);
      if (frame_done) fd_cnt++;
      fd_pend = 0;
      if (out_valid && bp_left > 0) begin
        out_ready = 0;
        if (bp_left < 10) begin
          check("bp_row_stable", out_row, snap);
          check("bp_in_ready", in_ready, 0);
        end
        snap = out_row;
        bp_left--;
      end else out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_row", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("row", out_row, e.row);
          check("last", out_last, e.last);
          fd_pend = e.last;
          got_q.push_back(out_row);
        end
      end
    end
  end

  initial begin
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_row", out_row, 0);
    @(posedge clk);
    #2 reset = 1;
    @(posedge clk);
    #1 check("ready_after_reset", in_ready, 1);
    fill_img(5);
    send_row(0, 0);
    send_row(1, 0);
    repeat (3) @(negedge clk);
    check("idle_discard_busy", busy, 0);
    fill_img(1);
    set_flt_default();
    got_q.delete();
    send_frame(1, H);
    drain();
    check("pad_rows", got_q.size(), 4);
    check("pad_corner", word(got_q[0], 0, 0), 4);
    check("pad_edge", word(got_q[0], 0, 1), 6);
    check("pad_edge_left", word(got_q[1], 0, 0), 6);
    check("pad_interior", word(got_q[1], 0, 1), 9);
    check("pad_bottom_corner", word(got_q[3], 0, 3), 4);
    check("pad_centre_filter", word(got_q[2], 1, 2), 1);
    fill_img(32767);
    got_q.delete();
    send_frame(1, H);
    drain();
    check("sat_pos", word(got_q[1], 0, 1), 16'h7FFF);
    check("sat_pos_centre", word(got_q[0], 1, 0), 16'h7FFF);
    fill_img(-32768);
    got_q.delete();
    send_frame(1, H);
    drain();
    check("sat_neg", word(got_q[1], 0, 1), 16'h8000);
    fill_img(1);
    got_q.delete();
    send_frame(0, H);
    drain();
    check("valid_rows", got_q.size(), 2);
    check("valid_c0", word(got_q[0], 0, 0), 9);
    check("valid_c1", word(got_q[1], 0, 1), 9);
    check("valid_c2", word(got_q[0], 0, 2), 0);
    check("valid_c3", word(got_q[1], 0, 3), 0);
    check("valid_centre", word(got_q[0], 1, 0), 1);
    randomize_data(0);
    bp_left = 10;
    send_frame(1, H);
    drain();
    check("bp_consumed", bp_left, 0);
    randomize_data(0);
    send_frame(1, 2);
    randomize_data(0);
    send_frame(1, H);
    drain();
    randomize_data(0);
    sel = 0;
    send_row(0, 1);
    send_row(1, 0);
    check("mid_busy", busy, 1);
    check("mid_in_ready", in_ready, 0);
    #1 reset = 0;
    #1 check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_row", out_row, 0);
    @(posedge clk);
    #2 reset = 1;
    @(posedge clk);
    #1 check("mid_ready_after_reset", in_ready, 1);
    randomize_data(1);
    send_frame(1, H);
    drain();
    for (int it = 0; it < 14; it++) begin
      bit pad = 1'($urandom_range(0, 1));
      randomize_data(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) bp_left = 10;
      if ($urandom_range(0, 3) == 0) begin
        send_frame(pad, $urandom_range(1, H - 1));
        randomize_data(0);
      end
      send_frame(pad, H);
      drain();
    end
    check("frame_done_count", fd_cnt, frames_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_row_engine.md
CONV_ROW_ENGINE -- requirements
Module: conv_row_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH 16, signed fixed-point word; FRAC 8, fractional bits; D 1, channels; H 64, rows per frame; W 64, pixels per row; F 3, odd filter size >=1; K 2, filter count; PAD 1 (1 = same/zero-padded, 0 = valid-only).
REQ-002 SHALL have ports (name  direction  width  meaning): clk  in  1  clock; reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have port filters  in  K*D*F*F*DATA_WIDTH  coefficients; word ((k*D+d)*F+r)*F+c, word 0 at bits [0:DATA_WIDTH-1].
REQ-004 SHALL have port in_row  in  D*W*DATA_WIDTH  one image row; word d*W+c.
REQ-005 SHALL have ports in_valid  in  1; in_first  in  1  row is frame row 0; in_ready  out  1.
REQ-006 SHALL have port out_row  out  K*W*DATA_WIDTH  one output row; word k*W+c.
REQ-007 SHALL have ports out_valid  out  1; out_ready  in  1; out_last  out  1  final row of frame.
REQ-008 SHALL have ports frame_done  out  1  one-cycle pulse; busy  out  1  state != IDLE.

Function
REQ-009 SHALL implement states IDLE, FILL, COMPUTE, HOLD, FLUSH; P = F/2 (integer).
REQ-010 SHALL assert in_ready only in IDLE and FILL; a row is accepted on a posedge with in_valid && in_ready.
REQ-011 SHALL, in IDLE, discard accepted rows with in_first=0; an accepted row with in_first=1 latches filters, clears the F-row circular line buffer to zero, stores the row, sets row count to 1, and enters FILL.
REQ-012 SHALL, in FILL, treat an accepted row with in_first=1 as a frame restart per REQ-011 (partial frame abandoned, no out_last, no frame_done).
REQ-013 SHALL, PAD=1: compute output row o after input row min(o+P, H-1) is accepted; output H rows; rows above 0 and below H-1 and columns outside 0..W-1 read as zero.
REQ-014 SHALL, PAD=0: compute output row o after input row o+F-1 is accepted; output H-F+1 rows of W-F+1 valid columns, words for columns W-F+1..W-1 zero.
REQ-015 SHALL, in COMPUTE, produce one output column for all K filters per cycle (W cycles per row), then enter HOLD.
REQ-016 SHALL hold out_valid=1 and out_row/out_last stable in HOLD until out_ready=1; on that handshake go to FLUSH if PAD=1, all H inputs received and output rows remain, else FILL if rows remain, else IDLE.
REQ-017 SHALL, in FLUSH, accept no input and enter COMPUTE immediately with zero bottom rows.
REQ-018 SHALL, if fewer than P+1 rows (PAD=1) or F rows (PAD=0) are buffered, remain in FILL without computing.
REQ-019 SHALL multiply full-precision signed, accumulate D*F*F products at 2*DATA_WIDTH+clog2(D*F*F) bits without overflow, arithmetic-shift right by FRAC, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-020 SHALL assert out_last with the final row of a frame and pulse frame_done the cycle after its handshake.
REQ-021 SHALL ignore filters except at the latch in REQ-011.

Reset
REQ-022 SHALL, while reset=0, asynchronously force state IDLE, in_ready=0, out_valid=0, out_last=0, frame_done=0, busy=0, out_row=0, row counters=0.
REQ-023 SHALL drive in_ready=1 the first posedge after reset deasserts; reset mid-frame discards all buffered and pending rows.

Verification (DATA_WIDTH=16, FRAC=0, D=1, H=4, W=4, F=3, K=2 unless stated)
REQ-024 Reset: reset low mid-COMPUTE -> out_valid=0, busy=0 immediately; in_ready=1 after release; no stale row appears.
REQ-025 PAD=1, all pixels 1, filter0 all 1, filter1 centre 1 -> filter0 corners 4, edges 6, interior 9; filter1 all 1; 4 rows, out_last on 4th, frame_done one pulse.
REQ-026 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_row stable, in_ready=0, no input lost.
REQ-027 Saturation: pixels 0x7FFF, filter0 all 1 -> 0x7FFF; pixels 0x8000 -> 0x8000.
REQ-028 PAD=0, all ones -> 2 rows, columns 0-1 = 9, columns 2-3 = 0; out_last on 2nd.
REQ-029 in_first on row 2 of a frame -> frame restarts, no out_last/frame_done for aborted frame; rows with in_first=0 in IDLE consumed and ignored.
